// File: rtl/reg_latch_queue.sv
// Registered FIFO queue: latch pushes data_in, en pops the head into data_out.
// Define REG_LATCH_QUEUE_PARITY_EN to add per-entry even parity (par_inj, parity_err).
module reg_latch_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     latch,
  input  logic                     en,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         data_in,
`ifdef REG_LATCH_QUEUE_PARITY_EN
  input  logic                     par_inj,
  output logic                     parity_err,
`endif
  output logic [WIDTH-1:0]         data_out,
  output logic                     out_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             pop_ok;
  logic             push_ok;
  logic [CW-1:0]    count_next;

  // A full queue still accepts a push when a pop frees the head slot on the same edge.
  assign pop_ok     = en && !empty;
  assign push_ok    = latch && (!full || pop_ok);
  assign count_next = count + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem[tail] <= data_in;
    end
  end

`ifdef REG_LATCH_QUEUE_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      par_mem[tail] <= (^data_in) ^ par_inj;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (clr) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= pop_ok && ((^mem[head]) != par_mem[head]);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      data_out  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pop_ok) begin
        data_out <= mem[head];
        head     <= head + AW'(1);
      end
      if (push_ok) begin
        tail <= tail + AW'(1);
      end
      out_valid <= pop_ok;
      count     <= count_next;
      full      <= (count_next == CW'(DEPTH));
      empty     <= (count_next == '0);
      if (latch && !push_ok) begin
        overflow <= 1'b1;
      end
      if (en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_latch_queue.sv
// Self-checking bench for reg_latch_queue: directed scenarios then random traffic
// compared against a queue-based reference model.
module tb_reg_latch_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             latch;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
`ifdef REG_LATCH_QUEUE_PARITY_EN
  logic             par_inj;
  logic             parity_err;
`endif

  reg_latch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .latch     (latch),
    .en        (en),
    .clr       (clr),
    .data_in   (data_in),
`ifdef REG_LATCH_QUEUE_PARITY_EN
    .par_inj   (par_inj),
    .parity_err(parity_err),
`endif
    .data_out  (data_out),
    .out_valid (out_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of data plus a queue of "parity was corrupted" flags.
  logic [WIDTH-1:0] mQ[$];
  bit               mInj[$];
  logic [WIDTH-1:0] mDout;
  bit               mValid;
  bit               mOvf;
  bit               mUdf;
  bit               mPerr;

  int nAssert = 0;
  int nFail   = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mInj.delete();
    mDout  = '0;
    mValid = 0;
    mOvf   = 0;
    mUdf   = 0;
    mPerr  = 0;
  endtask

  task automatic modelStep(input bit l, input bit e, input bit c,
                           input logic [WIDTH-1:0] d, input bit inj);
    bit popOk;
    bit pushOk;
    bit wasEmpty;
    if (c) begin
      mQ.delete();
      mInj.delete();
      mValid = 0;
      mOvf   = 0;
      mUdf   = 0;
      mPerr  = 0;
    end else begin
      wasEmpty = (mQ.size() == 0);
      popOk    = e && !wasEmpty;
      pushOk   = l && ((mQ.size() < DEPTH) || popOk);
      mValid   = popOk;
      mPerr    = 0;
      if (popOk) begin
        mDout = mQ.pop_front();
        mPerr = mInj.pop_front();
      end
      if (pushOk) begin
        mQ.push_back(d);
        mInj.push_back(inj);
      end
      if (l && !pushOk) mOvf = 1;
      if (e && wasEmpty) mUdf = 1;
    end
  endtask

  task automatic checkOutput(input string step);
    checkVal({step, ".data_out"},  64'(data_out),  64'(mDout));
    checkVal({step, ".out_valid"}, 64'(out_valid), 64'(mValid));
    checkVal({step, ".count"},     64'(count),     64'(mQ.size()));
    checkVal({step, ".full"},      64'(full),      64'(mQ.size() == DEPTH));
    checkVal({step, ".empty"},     64'(empty),     64'(mQ.size() == 0));
    checkVal({step, ".overflow"},  64'(overflow),  64'(mOvf));
    checkVal({step, ".underflow"}, 64'(underflow), 64'(mUdf));
`ifdef REG_LATCH_QUEUE_PARITY_EN
    checkVal({step, ".parity_err"}, 64'(parity_err), 64'(mPerr));
`endif
  endtask

  // Called at a negedge: drive, take one rising edge, advance the model, check at next negedge.
  task automatic applyStimulus(input string step, input bit l, input bit e, input bit c,
                               input logic [WIDTH-1:0] d, input bit inj = 0);
    latch   = l;
    en      = e;
    clr     = c;
    data_in = d;
`ifdef REG_LATCH_QUEUE_PARITY_EN
    par_inj = inj;
`endif
    @(posedge clk);
    modelStep(l, e, c, d, inj);
    @(negedge clk);
    checkOutput(step);
  endtask

  initial begin
    logic [WIDTH-1:0] fillVals [4];
    fillVals = '{8'h11, 8'h22, 8'h33, 8'h44};

    latch   = 0;
    en      = 0;
    clr     = 0;
    data_in = '0;
`ifdef REG_LATCH_QUEUE_PARITY_EN
    par_inj = 0;
`endif
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    modelReset();
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1;

    // Fill and drain in order
    foreach (fillVals[i]) applyStimulus("fill", 1, 0, 0, fillVals[i]);
    for (int i = 0; i < 4; i++) applyStimulus("drain", 0, 1, 0, '0);
    applyStimulus("idle", 0, 0, 0, '0);

    // Overflow on a full queue, then underflow on empty
    foreach (fillVals[i]) applyStimulus("fill2", 1, 0, 0, fillVals[i]);
    applyStimulus("ovf_push", 1, 0, 0, 8'h55);
    for (int i = 0; i < 4; i++) applyStimulus("ovf_drain", 0, 1, 0, '0);
    applyStimulus("udf_pop", 0, 1, 0, '0);

    // Flush takes priority over a push
    applyStimulus("push_b", 1, 0, 0, 8'hBB);
    applyStimulus("clr", 1, 1, 1, 8'hCC);
    applyStimulus("after_clr", 0, 0, 0, '0);

    // No bypass through an empty queue
    applyStimulus("nobypass", 1, 1, 0, 8'hA5);
    applyStimulus("pop_a5", 0, 1, 0, '0);

    // Simultaneous push/pop on full queue, wrapping pointers
    foreach (fillVals[i]) applyStimulus("fill3", 1, 0, 0, fillVals[i]);
    applyStimulus("full_pushpop", 1, 1, 0, 8'h66);
    for (int i = 0; i < 4; i++) applyStimulus("wrap_drain", 0, 1, 0, '0);

    // Asynchronous reset between clock edges with entries queued
    applyStimulus("pre_rst1", 1, 0, 0, 8'h77);
    applyStimulus("pre_rst2", 1, 0, 0, 8'h88);
    #2 rst_n = 0;
    #1;
    modelReset();
    checkOutput("rst_mid");
    @(negedge clk);
    rst_n = 1;
    applyStimulus("post_rst_pop", 0, 1, 0, '0);

`ifdef REG_LATCH_QUEUE_PARITY_EN
    applyStimulus("par_push_inj", 1, 0, 0, 8'h0F, 1);
    applyStimulus("par_pop_inj", 0, 1, 0, '0);
    applyStimulus("par_idle", 0, 0, 0, '0);
    applyStimulus("par_push_ok", 1, 0, 0, 8'h0F, 0);
    applyStimulus("par_pop_ok", 0, 1, 0, '0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 31) == 0),
                    WIDTH'($urandom),
                    ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/reg_latch_queue.md
REG_LATCH_QUEUE -- requirements
Module: reg_latch_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries (power of two, 2..64).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port latch, input, 1 bit: push data_in into the queue tail.
REQ-006 The block SHALL have port en, input, 1 bit: pop the queue head onto data_out.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous flush.
REQ-008 The block SHALL have port data_in, input, WIDTH bits: push data.
REQ-009 The block SHALL have port data_out, output, WIDTH bits: registered data from the last successful pop.
REQ-010 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a data_out update.
REQ-011 The block SHALL have ports full and empty, output, 1 bit each: occupancy flags, registered.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 The block SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.

Function
REQ-014 Push accepted iff latch=1 and (full=0 or a pop is accepted in the same cycle); entry written at the tail; tail pointer advances modulo DEPTH.
REQ-015 Pop accepted iff en=1 and empty=0; head entry registered into data_out on the same edge; out_valid=1 for the following cycle only; head pointer advances modulo DEPTH.
REQ-016 When no pop is accepted, data_out SHALL hold its value and out_valid SHALL be 0.
REQ-017 There is no bypass: with empty=1 and latch=en=1, the push is accepted, the pop is not, and count increments by 1.
REQ-018 With full=1 and latch=en=1, both are accepted, count stays at DEPTH, and the old head appears on data_out.
REQ-019 A rejected push (latch=1, full=1, en=0) drops data_in and sets overflow; queue contents are unchanged.
REQ-020 A rejected pop (en=1, empty=1) sets underflow; data_out holds.
REQ-021 count SHALL equal pushes minus pops accepted; full = (count==DEPTH); empty = (count==0); all are registered with no extra latency.
REQ-022 clr=1 SHALL set both pointers and count to 0, empty=1, full=0, and clear overflow, underflow and out_valid; it has priority over latch/en in the same cycle; data_out holds.
REQ-023 Stored entries not yet popped SHALL be unaffected by pointer wrap-around.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, set data_out=0, out_valid=0, count=0, empty=1, full=0, overflow=0, underflow=0, and both pointers to 0.
REQ-025 Storage array contents need not be reset; they SHALL never reach data_out before being written.
REQ-026 Reset asserted mid-operation discards all queued entries; the first pop after release returns only data pushed after release.

Configuration
REQ-027 With macro REG_LATCH_QUEUE_PARITY_EN defined, each entry SHALL store an even-parity bit computed from data_in at push.
REQ-028 With the macro defined, the block SHALL add input par_inj (1 bit, inverts the stored parity bit on that push) and output parity_err (1 bit).
REQ-029 parity_err SHALL pulse with out_valid when the recomputed parity of the popped data mismatches the stored bit; reset value 0.
REQ-030 Without the macro, the parity storage, par_inj and parity_err SHALL be absent and behaviour is otherwise identical.

Verification
REQ-031 Reset, push 0x11,0x22,0x33,0x44 (DEPTH=4) -> full=1, count=4; then pop x4 -> data_out 0x11,0x22,0x33,0x44, each with a one-cycle out_valid; empty=1.
REQ-032 Full queue, push 0x55 with en=0 -> overflow=1, count=4; subsequent pops return 0x11..0x44 only.
REQ-033 Empty queue, latch=en=1 with data 0xA5 -> no out_valid, count=1; next pop -> data_out=0xA5.
REQ-034 Full queue, latch=en=1 with 0x66 -> data_out=0x11, count=4; draining yields 0x22,0x33,0x44,0x66 (wrap-around check).
REQ-035 Two entries queued, assert rst_n=0 between clock edges -> outputs clear immediately; pop after release -> underflow=1, data_out=0x00.
REQ-036 With REG_LATCH_QUEUE_PARITY_EN: push 0x0F with par_inj=1, then pop -> data_out=0x0F, parity_err=1 for one cycle; a push with par_inj=0 then pop -> parity_err=0.
